// File: rtl/ahb_arbiter_rr.sv
// rtl/ahb_arbiter_rr.sv - AHB bus arbiter, fixed-priority or round-robin
// Grant never moves mid fixed-length burst or while the owner holds HLOCK.
module ahb_arbiter_rr #(
  parameter int P_NUMM        = 2,
  parameter int P_DEFAULT_MST = 0,
  parameter int P_ARB_MODE    = 1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [P_NUMM-1:0] HBUSREQ,
  input  logic [P_NUMM-1:0] HLOCK,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HBURST,
  input  logic              HREADY,
  output logic [P_NUMM-1:0] HGRANT,
  output logic [3:0]        HMASTER,
  output logic              HMASTLOCK
);
  localparam logic [3:0]        DFLT_IDX = 4'(P_DEFAULT_MST);
  localparam logic [P_NUMM-1:0] DFLT_GNT = {{(P_NUMM-1){1'b0}}, 1'b1} << P_DEFAULT_MST;

  logic [P_NUMM-1:0] grant_r;
  logic [P_NUMM-1:0] grant_nxt;
  logic [3:0]        master_r;
  logic              lock_r;
  logic [3:0]        beat_cnt;
  logic [3:0]        last_r;
  logic [3:0]        gnt_idx;
  logic [3:0]        sel_idx;
  logic [3:0]        len_m1;
  logic [3:0]        cnt_next;
  logic              owner_lock;
  logic              arb_ok;

  always_comb begin
    gnt_idx    = 4'd0;
    owner_lock = 1'b0;
    for (int i = 0; i < P_NUMM; i++) begin
      if (grant_r[i]) begin
        gnt_idx    = 4'(i);
        owner_lock = HLOCK[i];
      end
    end
  end

  always_comb begin
    len_m1 = 4'd0;
    case (HBURST)
      3'd2, 3'd3: len_m1 = 4'd3;
      3'd4, 3'd5: len_m1 = 4'd7;
      3'd6, 3'd7: len_m1 = 4'd15;
      default:    len_m1 = 4'd0;
    endcase
  end

  // Early IDLE/NONSEQ reloads the count, so a truncated burst frees the bus at once.
  always_comb begin
    cnt_next = 4'd0;
    case (HTRANS)
      2'b10:   cnt_next = len_m1;
      2'b11:   cnt_next = (beat_cnt == 4'd0) ? 4'd0 : beat_cnt - 4'd1;
      2'b01:   cnt_next = beat_cnt;
      default: cnt_next = 4'd0;
    endcase
  end

  assign arb_ok = HREADY & ~owner_lock & (cnt_next == 4'd0);

  // Rank 0 wins; in round-robin the last owner ranks last.
  always_comb begin
    int best;
    int rank;
    sel_idx = DFLT_IDX;
    best    = P_NUMM;
    rank    = 0;
    for (int i = 0; i < P_NUMM; i++) begin
      if (P_ARB_MODE == 0) begin
        rank = i;
      end else begin
        rank = i - int'(last_r) - 1;
        if (rank < 0) rank = rank + P_NUMM;
      end
      if (HBUSREQ[i] && rank < best) begin
        best    = rank;
        sel_idx = 4'(i);
      end
    end
  end

  always_comb begin
    grant_nxt = '0;
    for (int i = 0; i < P_NUMM; i++) grant_nxt[i] = (sel_idx == 4'(i));
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      grant_r  <= DFLT_GNT;
      master_r <= DFLT_IDX;
      lock_r   <= 1'b0;
      beat_cnt <= 4'd0;
      last_r   <= DFLT_IDX;
    end else if (HREADY) begin
      beat_cnt <= cnt_next;
      master_r <= gnt_idx;
      lock_r   <= owner_lock;
      if (arb_ok && sel_idx != gnt_idx) begin
        grant_r <= grant_nxt;
        last_r  <= sel_idx;
      end
    end
  end

  assign HGRANT    = grant_r;
  assign HMASTER   = master_r;
  assign HMASTLOCK = lock_r;
endmodule
